// File: rtl/id_stage_pipe.sv
// Integer-pipeline decode stage: decodes OP-IMM and, optionally, OP instructions,
// drives the register-file read ports and holds the result in an ID/EX register.
module id_stage_pipe #(
   parameter int          DATA_WIDTH    = 32,
   parameter int          RADDR_WIDTH   = 5,
   parameter int unsigned SUPPORT_RTYPE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic [31:0]            inst_i,
   input  logic                   inst_valid_i,
   output logic                   inst_ready_o,
   input  logic [DATA_WIDTH-1:0]  reg1_rdata_i,
   input  logic [DATA_WIDTH-1:0]  reg2_rdata_i,
   output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
   output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
   output logic                   reg1_re_o,
   output logic                   reg2_re_o,
   output logic                   ex_valid_o,
   input  logic                   ex_ready_i,
   output logic [DATA_WIDTH-1:0]  op1_o,
   output logic [DATA_WIDTH-1:0]  op2_o,
   output logic [3:0]             alu_op_o,
   output logic                   reg_we_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   illegal_o
);

   localparam int SHAMT_W = (DATA_WIDTH == 64) ? 6 : 5;
   localparam int UP_W    = 12 - SHAMT_W;

   // srai marker sits one bit below the top of the bits above shamt
   localparam logic [UP_W-1:0] SRAI_PAT = UP_W'(1) << (UP_W - 2);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [4:0]            rd;
   logic [UP_W-1:0]       shamt_hi;
   logic [DATA_WIDTH-1:0] imm_sext;
   logic [DATA_WIDTH-1:0] shamt_ext;
   logic                  is_opimm;
   logic                  is_op;

   logic                   dec_illegal;
   logic [3:0]             dec_alu;
   logic [DATA_WIDTH-1:0]  dec_op1;
   logic [DATA_WIDTH-1:0]  dec_op2;
   logic                   dec_we;
   logic [RADDR_WIDTH-1:0] dec_waddr;

   logic                   ex_valid_q;
   logic [DATA_WIDTH-1:0]  op1_q;
   logic [DATA_WIDTH-1:0]  op2_q;
   logic [3:0]             alu_op_q;
   logic                   reg_we_q;
   logic [RADDR_WIDTH-1:0] reg_waddr_q;
   logic                   illegal_q;
   logic                   accept;

   assign opcode    = inst_i[6:0];
   assign rd        = inst_i[11:7];
   assign funct3    = inst_i[14:12];
   assign funct7    = inst_i[31:25];
   assign shamt_hi  = inst_i[31:20+SHAMT_W];
   assign imm_sext  = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
   assign shamt_ext = DATA_WIDTH'(inst_i[20 +: SHAMT_W]);
   assign is_opimm  = (opcode == OPC_OP_IMM);
   assign is_op     = (SUPPORT_RTYPE != 0) && (opcode == OPC_OP);

   always_comb begin
      reg1_raddr_o = '0;
      reg2_raddr_o = '0;
      reg1_re_o    = 1'b0;
      reg2_re_o    = 1'b0;
      if (inst_valid_i) begin
         if (is_opimm) begin
            reg1_raddr_o = RADDR_WIDTH'(inst_i[19:15]);
            reg1_re_o    = 1'b1;
         end else if (is_op) begin
            reg1_raddr_o = RADDR_WIDTH'(inst_i[19:15]);
            reg2_raddr_o = RADDR_WIDTH'(inst_i[24:20]);
            reg1_re_o    = 1'b1;
            reg2_re_o    = 1'b1;
         end
      end
   end

   always_comb begin
      dec_illegal = 1'b1;
      dec_alu     = ALU_ADD;
      dec_op1     = '0;
      dec_op2     = '0;
      if (is_opimm) begin
         dec_illegal = 1'b0;
         dec_op1     = reg1_rdata_i;
         dec_op2     = imm_sext;
         case (funct3)
            3'b000: dec_alu = ALU_ADD;
            3'b010: dec_alu = ALU_SLT;
            3'b011: dec_alu = ALU_SLTU;
            3'b100: dec_alu = ALU_XOR;
            3'b110: dec_alu = ALU_OR;
            3'b111: dec_alu = ALU_AND;
            3'b001: begin
               dec_alu     = ALU_SLL;
               dec_op2     = shamt_ext;
               dec_illegal = (shamt_hi != '0);
            end
            3'b101: begin
               dec_op2 = shamt_ext;
               if (shamt_hi == '0)
                  dec_alu = ALU_SRL;
               else if (shamt_hi == SRAI_PAT)
                  dec_alu = ALU_SRA;
               else
                  dec_illegal = 1'b1;
            end
         endcase
      end else if (is_op) begin
         dec_op1 = reg1_rdata_i;
         dec_op2 = reg2_rdata_i;
         if (funct7 == 7'b0000000) begin
            dec_illegal = 1'b0;
            case (funct3)
               3'b000: dec_alu = ALU_ADD;
               3'b001: dec_alu = ALU_SLL;
               3'b010: dec_alu = ALU_SLT;
               3'b011: dec_alu = ALU_SLTU;
               3'b100: dec_alu = ALU_XOR;
               3'b101: dec_alu = ALU_SRL;
               3'b110: dec_alu = ALU_OR;
               3'b111: dec_alu = ALU_AND;
            endcase
         end else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000) begin
               dec_illegal = 1'b0;
               dec_alu     = ALU_SUB;
            end else if (funct3 == 3'b101) begin
               dec_illegal = 1'b0;
               dec_alu     = ALU_SRA;
            end
         end
      end
      // an illegal instruction travels down the pipe as an inert bubble with a flag
      if (dec_illegal) begin
         dec_alu = ALU_ADD;
         dec_op1 = '0;
         dec_op2 = '0;
      end
   end

   assign dec_we    = !dec_illegal && (rd != 5'd0);
   assign dec_waddr = dec_illegal ? '0 : RADDR_WIDTH'(rd);

   assign inst_ready_o = !flush_i && (!ex_valid_q || ex_ready_i);
   assign accept       = inst_valid_i && inst_ready_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         alu_op_q    <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         illegal_q   <= 1'b0;
      end else if (flush_i) begin
         ex_valid_q <= 1'b0;
         reg_we_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (accept) begin
         ex_valid_q  <= 1'b1;
         op1_q       <= dec_op1;
         op2_q       <= dec_op2;
         alu_op_q    <= dec_alu;
         reg_we_q    <= dec_we;
         reg_waddr_q <= dec_waddr;
         illegal_q   <= dec_illegal;
      end else if (ex_ready_i) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid_o  = ex_valid_q;
   assign op1_o       = op1_q;
   assign op2_o       = op2_q;
   assign alu_op_o    = alu_op_q;
   assign reg_we_o    = reg_we_q;
   assign reg_waddr_o = reg_waddr_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: 32-bit with R-type, 64-bit, and 32-bit without R-type.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        ex_ready;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [63:0] rd1_64;
   logic [63:0] rd2_64;

   always #5 clk = ~clk;

   assign rd1_64 = {32'b0, rd1};
   assign rd2_64 = {32'b0, rd2};

   logic        a_ready, a_re1, a_re2, a_valid, a_we, a_ill;
   logic [4:0]  a_ra1, a_ra2, a_wa;
   logic [31:0] a_op1, a_op2;
   logic [3:0]  a_alu;

   logic        b_ready, b_re1, b_re2, b_valid, b_we, b_ill;
   logic [4:0]  b_ra1, b_ra2, b_wa;
   logic [63:0] b_op1, b_op2;
   logic [3:0]  b_alu;

   logic        c_ready, c_re1, c_re2, c_valid, c_we, c_ill;
   logic [4:0]  c_ra1, c_ra2, c_wa;
   logic [31:0] c_op1, c_op2;
   logic [3:0]  c_alu;

   id_stage_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .SUPPORT_RTYPE(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .inst_i(inst), .inst_valid_i(inst_valid),
      .inst_ready_o(a_ready), .reg1_rdata_i(rd1), .reg2_rdata_i(rd2),
      .reg1_raddr_o(a_ra1), .reg2_raddr_o(a_ra2), .reg1_re_o(a_re1), .reg2_re_o(a_re2),
      .ex_valid_o(a_valid), .ex_ready_i(ex_ready), .op1_o(a_op1), .op2_o(a_op2),
      .alu_op_o(a_alu), .reg_we_o(a_we), .reg_waddr_o(a_wa), .illegal_o(a_ill));

   id_stage_pipe #(.DATA_WIDTH(64), .RADDR_WIDTH(5), .SUPPORT_RTYPE(1)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .inst_i(inst), .inst_valid_i(inst_valid),
      .inst_ready_o(b_ready), .reg1_rdata_i(rd1_64), .reg2_rdata_i(rd2_64),
      .reg1_raddr_o(b_ra1), .reg2_raddr_o(b_ra2), .reg1_re_o(b_re1), .reg2_re_o(b_re2),
      .ex_valid_o(b_valid), .ex_ready_i(ex_ready), .op1_o(b_op1), .op2_o(b_op2),
      .alu_op_o(b_alu), .reg_we_o(b_we), .reg_waddr_o(b_wa), .illegal_o(b_ill));

   id_stage_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .SUPPORT_RTYPE(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .inst_i(inst), .inst_valid_i(inst_valid),
      .inst_ready_o(c_ready), .reg1_rdata_i(rd1), .reg2_rdata_i(rd2),
      .reg1_raddr_o(c_ra1), .reg2_raddr_o(c_ra2), .reg1_re_o(c_re1), .reg2_re_o(c_re2),
      .ex_valid_o(c_valid), .ex_ready_i(ex_ready), .op1_o(c_op1), .op2_o(c_op2),
      .alu_op_o(c_alu), .reg_we_o(c_we), .reg_waddr_o(c_wa), .illegal_o(c_ill));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic v, input logic [31:0] r1, input logic [31:0] r2);
      inst       = i;
      inst_valid = v;
      rd1        = r1;
      rd2        = r2;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; inst = '0; inst_valid = 1'b0; ex_ready = 1'b1;
      rd1 = '0; rd2 = '0;
      tick(); tick();
      check("rst_valid", a_valid, 0);
      check("rst_op2", a_op2, 0);
      check("rst_we", a_we, 0);
      check("rst_ill", a_ill, 0);
      rst_n = 1'b1;

      // ori x1,x0,0x0F0
      drive(32'h0F006093, 1, 0, 0);
      check("ori_ra1", a_ra1, 0);
      check("ori_re1", a_re1, 1);
      check("ori_re2", a_re2, 0);
      check("ori_ready", a_ready, 1);
      tick();
      check("ori_valid", a_valid, 1);
      check("ori_op1", a_op1, 0);
      check("ori_op2", a_op2, 64'h0F0);
      check("ori_alu", a_alu, 8);
      check("ori_we", a_we, 1);
      check("ori_wa", a_wa, 1);

      // addi x2,x1,-1
      drive(32'hFFF08113, 1, 5, 0);
      check("addi_ra1", a_ra1, 1);
      tick();
      check("addi_op1", a_op1, 5);
      check("addi_op2", a_op2, 64'hFFFF_FFFF);
      check("addi_alu", a_alu, 0);
      check("addi_wa", a_wa, 2);
      check("addi64_op2", b_op2, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi64_op1", b_op1, 5);

      // srai x3,x1,4
      drive(32'h4040D193, 1, 5, 0);
      tick();
      check("srai_alu", a_alu, 7);
      check("srai_op2", a_op2, 4);
      check("srai_wa", a_wa, 3);
      check("srai_ill", a_ill, 0);
      check("srai64_alu", b_alu, 7);

      // inst[25]=1: illegal at 32 bits, srai by 36 at 64 bits
      drive(32'h4240D193, 1, 5, 0);
      tick();
      check("srai25_ill", a_ill, 1);
      check("srai25_we", a_we, 0);
      check("srai25_op1", a_op1, 0);
      check("srai25_wa", a_wa, 0);
      check("srai25_valid", a_valid, 1);
      check("srai64_36_ill", b_ill, 0);
      check("srai64_36_op2", b_op2, 36);

      // add x4,x1,x2
      drive(32'h00208233, 1, 7, 3);
      check("add_re1", a_re1, 1);
      check("add_re2", a_re2, 1);
      check("add_ra2", a_ra2, 2);
      tick();
      check("add_op1", a_op1, 7);
      check("add_op2", a_op2, 3);
      check("add_alu", a_alu, 0);
      check("add_wa", a_wa, 4);
      check("add_nr_ill", c_ill, 1);
      check("add_nr_we", c_we, 0);

      drive(32'h40208233, 1, 7, 3);
      tick();
      check("sub_alu", a_alu, 1);
      check("sub_ill", a_ill, 0);

      // funct7 0100000 with xor is illegal
      drive(32'h4020C233, 1, 7, 3);
      tick();
      check("xor7_ill", a_ill, 1);
      check("xor7_op2", a_op2, 0);

      drive(32'h00000000, 1, 7, 3);
      check("badop_re1", a_re1, 0);
      tick();
      check("badop_ill", a_ill, 1);

      // backpressure
      drive(32'hFFF08113, 1, 5, 0);
      tick();
      ex_ready = 1'b0;
      drive(32'h0F006093, 1, 0, 0);
      check("bp_ready", a_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_valid", a_valid, 1);
         check("bp_op1", a_op1, 5);
         check("bp_alu", a_alu, 0);
         check("bp_wa", a_wa, 2);
         check("bp_ready_hold", a_ready, 0);
      end
      ex_ready = 1'b1;
      #1;
      check("bp_ready_rel", a_ready, 1);
      tick();
      check("bp_new_alu", a_alu, 8);
      check("bp_new_wa", a_wa, 1);
      check("bp_new_valid", a_valid, 1);
      drive(32'h0F006093, 0, 0, 0);
      tick();
      check("bp_drain", a_valid, 0);

      // flush during stall
      drive(32'hFFF08113, 1, 5, 0);
      tick();
      ex_ready = 1'b0;
      flush    = 1'b1;
      #1;
      check("fl_ready", a_ready, 0);
      tick();
      check("fl_valid", a_valid, 0);
      check("fl_we", a_we, 0);
      flush = 1'b0;
      drive(32'h0, 0, 0, 0);
      tick();
      check("fl_after", a_valid, 0);

      // reset while stalled
      drive(32'hFFF08113, 1, 5, 0);
      tick();
      check("rs_loaded", a_valid, 1);
      rst_n = 1'b0;
      tick();
      check("rs_valid", a_valid, 0);
      check("rs_op1", a_op1, 0);
      check("rs_op2", a_op2, 0);
      check("rs_wa", a_wa, 0);
      check("rs_we", a_we, 0);
      rst_n    = 1'b1;
      ex_ready = 1'b1;

      // addi x0,x1,1
      drive(32'h00108013, 1, 9, 0);
      tick();
      check("x0_valid", a_valid, 1);
      check("x0_we", a_we, 0);
      check("x0_ill", a_ill, 0);
      check("x0_op1", a_op1, 9);
      check("x0_op2", a_op2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage for the integer pipeline.
- Decodes all OP-IMM instructions: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
- Optionally decodes OP (R-type) instructions.
- Drives register-file read ports combinationally.
- Registers operands, ALU op, write-back control and an illegal flag into an ID/EX register with valid/ready handshake and flush.
- Sits between IF and EX.

Parameters:
- DATA_WIDTH, 32, operand/register width; 32 or 64.
- RADDR_WIDTH, 5, register address width.
- SUPPORT_RTYPE, 1, when 1 opcode 0110011 is decoded; when 0 it is illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- flush_i  in  1  kill ID/EX contents
- inst_i  in  32  instruction from IF
- inst_valid_i  in  1  inst_i valid
- inst_ready_o  out  1  stage can accept inst_i
- reg1_rdata_i  in  DATA_WIDTH  regfile port 1 data, same cycle
- reg2_rdata_i  in  DATA_WIDTH  regfile port 2 data, same cycle
- reg1_raddr_o  out  RADDR_WIDTH  regfile port 1 address (comb)
- reg2_raddr_o  out  RADDR_WIDTH  regfile port 2 address (comb)
- reg1_re_o  out  1  port 1 read enable (comb)
- reg2_re_o  out  1  port 2 read enable (comb)
- ex_valid_o  out  1  ID/EX holds an instruction
- ex_ready_i  in  1  EX accepts ID/EX contents
- op1_o  out  DATA_WIDTH  registered operand 1
- op2_o  out  DATA_WIDTH  registered operand 2
- alu_op_o  out  4  registered ALU op
- reg_we_o  out  1  registered write enable
- reg_waddr_o  out  RADDR_WIDTH  registered destination
- illegal_o  out  1  registered illegal-instruction flag

Behaviour:
- Read ports (combinational, when inst_valid_i=1):
  - OP-IMM: raddr1=rs1, re1=1, raddr2=0, re2=0.
  - OP: both ports on rs1/rs2, re=1.
  - Otherwise, or when inst_valid_i=0: addresses 0, enables 0.
- alu_op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- OP-IMM operands:
  - op1=reg1_rdata_i.
  - op2=inst[31:20] sign-extended to DATA_WIDTH.
  - Shifts use op2=shamt zero-extended. shamt is inst[24:20] for DATA_WIDTH=32, inst[25:20] for 64.
  - Shift legality, checked on the bits above shamt:
    - slli/srli require all-zero.
    - srai requires 0100000 (32) / 010000 (64).
    - DATA_WIDTH=32 with inst[25]=1 is illegal.
- OP operands:
  - op1=rdata1, op2=rdata2.
  - funct7 0000000 selects base op; 0100000 is legal only for add→SUB and srl→SRA; any other funct7 is illegal.
- Write-back: reg_we=1 and waddr=rd, except reg_we=0 when rd=0.
- Illegal instruction (bad opcode, funct7 or shamt): still loads the ID/EX register.
  - illegal_o=1, reg_we_o=0, op1/op2/alu_op=0, waddr=0.
- Handshake:
  - inst_ready_o = !ex_valid_o || ex_ready_i (combinational).
  - Load ID/EX when inst_valid_i && inst_ready_o.
  - Latency: 1 cycle from acceptance to ex_valid_o.
  - ex_valid_o clears when ex_ready_i=1 and no new instruction is accepted.
  - While ex_valid_o=1 and ex_ready_i=0, all registered outputs hold stable.
  - Back-to-back accept with ex_ready_i=1 gives full throughput.
- Flush: flush_i=1 at a clock edge clears ex_valid_o, reg_we_o and illegal_o, and accepts nothing that cycle. inst_ready_o is forced 0 while flush_i=1. Flush has priority over load.
- Reset: rst_n=0 at a clock edge sets all registered outputs to 0 (ex_valid_o=0). Reset has priority over flush and load.
  - Mid-stall reset discards the held instruction.
  - First acceptance is possible on the cycle after rst_n rises.

Test Plan:
- ori x1,x0,0x0F0 (0x0F006093), reg1_rdata=0, ex_ready=1 -> next cycle: ex_valid=1, op1=0, op2=0x000000F0, alu_op=8, reg_we=1, waddr=1; same cycle: raddr1=0, re1=1, re2=0.
- addi x2,x1,-1 (0xFFF08113), rdata1=5 -> op1=5, op2=0xFFFFFFFF, alu_op=0, waddr=2; also run with DATA_WIDTH=64 -> op2=0xFFFFFFFFFFFFFFFF.
- srai x3,x1,4 (0x4040D193) -> alu_op=7, op2=4; variant 0x4240D193 (inst[25]=1, DATA_WIDTH=32) -> illegal_o=1, reg_we=0.
- add x4,x1,x2 (0x00208233) / sub (0x40208233) with rdata 7/3 -> op1=7, op2=3, alu_op=0 / 1, re1=re2=1; with SUPPORT_RTYPE=0 -> illegal_o=1.
- Backpressure: accept addi, hold ex_ready=0 three cycles while a new valid inst is presented -> inst_ready_o=0, outputs unchanged; raise ex_ready -> new inst loads next edge, no loss or duplication.
- Flush during stall clears ex_valid next cycle; rst_n=0 with ex_valid=1 -> all outputs 0 next cycle; addi x0,x1,1 (0x00108013) -> reg_we_o=0, illegal_o=0.
